approx_seq_divider: RTL
=======================

# approx_seq_divider

Iterative, parametrised restoring array divider. It computes one quotient row per clock instead of instantiating the full subtractor array. A run-time switch selects, per request, whether the low `APPROX_ROWS` quotient rows use the approximate subtractor cell or the exact cell. It sits beside the combinational array dividers as the area-lean successor for error/latency exploration, with a valid/ready front end and back end.

## Interface
- `N_W`, default 16: dividend width.
- `D_W`, default 8: divisor and remainder width. Require `2 <= D_W < N_W`.
- `APPROX_ROWS`, default 4: number of least-significant quotient rows eligible for approximate cells. Require `0 <= APPROX_ROWS <= Q_W`.
- `Q_W` (derived, not overridable) = `N_W - D_W`: quotient width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: request accepted on the edge where `in_valid & in_ready`.
- `n`  in  N_W: dividend.
- `d`  in  D_W: divisor.
- `approx_en`  in  1: sampled with the request; 1 = approximate cells in rows `< APPROX_ROWS`.
- `out_valid`  out  1: result valid, held until accepted.
- `out_ready`  in  1: result consumed on the edge where `out_valid & out_ready`.
- `q`  out  Q_W: quotient.
- `r`  out  D_W: remainder.
- `dz`  out  1: divide-by-zero flag.
- `ovf`  out  1: `n[N_W-1:Q_W] >= d` (with `d != 0`); quotient truncated to `Q_W` bits.

## Operation
- **States:** IDLE, BUSY, DONE.
- **in_ready:** `in_ready = (IDLE) | (DONE & out_ready)`. This allows back-to-back requests.
- **Accept:** latch `d` and `approx_en`. Set `P = n[N_W-1:Q_W]` and `S = n[Q_W-1:0]`. Set row `k = Q_W-1`.
  - If `d == 0`: go to DONE, `q = all ones`, `r = n[D_W-1:0]`, `dz = 1`, `ovf = 0`.
  - Otherwise go to BUSY, `ovf` = compare result, `dz = 0`.
- **BUSY, one row per edge:**
  - Window `W = {P, S[k]}` (D_W+1 bits).
  - The row subtracts `d` from `W[D_W-1:0]` through a D_W-cell ripple borrow chain with borrow-in 0.
  - `qk = W[D_W] | ~borrow_out`.
  - Each cell outputs `diff` if `qk` is 1, else passes `x` unchanged. `P` takes those D_W outputs.
  - `q[k] = qk`. Decrement `k`. After row 0, go to DONE with `r = P`.
- **Cell selection:** row `k` uses approximate cells when `approx_en & (k < APPROX_ROWS)`; otherwise exact cells.
  - Exact cell: `diff = x^y^b`, `bout = (~x&y) | (~(x^y)&b)`.
  - Approximate cell: `diff = x|y|b`, `bout = x|~y|b`.
- **DONE:** `q`, `r`, `dz`, `ovf` are held stable while `out_valid = 1`.
  - On `out_valid & out_ready`: go to IDLE, unless a new request is accepted on the same edge, in which case take the Accept path.
- **Reset (any state, mid-operation included):** go to IDLE. `in_ready = 1`, `out_valid = 0`, `q = 0`, `r = 0`, `dz = 0`, `ovf = 0`, internal `P`, `S`, `k` cleared. The in-flight operation is discarded.
- **Input stability:** `n`, `d` and `approx_en` are ignored except on the accept edge.

## Timing
- **Accept edge = edge 0.** The BUSY rows occupy edges 1..`Q_W`. `out_valid` rises after edge `Q_W` (8 cycles at default).
- **Divide by zero:** `out_valid` rises after edge 0 (1 cycle).
- **Throughput:** one result per `Q_W+1` cycles with `out_ready` held high.
- **Back-pressure:** DONE persists indefinitely while `out_ready = 0`.
- **Critical path:** one D_W-cell borrow chain plus the row mux. No multi-row combinational paths.

## Structure
- **Package `approx_div_pkg`:** state enum (IDLE, BUSY, DONE) and cell-mode enum (EXACT, APPROX).
- **Sub-module `approx_div_row`:**
  - Parameters: `D_W`.
  - Inputs: window, `d`, mode.
  - Outputs: `qk`, next `P`.
  - Purely combinational.
  - Contains D_W cells selected by mode.

## Test plan
- **Exact path:** `n = 1000`, `d = 13`, `approx_en = 0`. Expect `q = 76`, `r = 12`, `dz = 0`, `ovf = 0`; `out_valid` 8 cycles after accept.
- **Approximate path, upper rows exact:** same operands with `approx_en = 1`. Expect `q[7:4] = 4'b0100`, matching the exact result. The full `q`/`r` must match a bit-accurate model of the cell equations.
- **Divide by zero:** `d = 0`, `n = 16'h1234`. Expect `dz = 1`, `q = 8'hFF`, `r = 8'h34`, `out_valid` 1 cycle after accept.
- **Overflow:** `n = 16'h2000`, `d = 16`. Expect `ovf = 1`; `q`/`r` equal the array result (truncated quotient).
- **Handshake:** hold `out_ready = 0` for 5 cycles, then assert it together with `in_valid`. Expect outputs stable throughout and the new request accepted on the same edge with no idle cycle.
- **Reset mid-operation:** drop `rst_n` at BUSY row 3. Expect immediate IDLE, `out_valid = 0`, `in_ready = 1`, and the next request producing a correct result.

Source files
------------

// File: rtl/approx_div_pkg.sv
// Shared types for the iterative approximate restoring divider.
package approx_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  typedef enum logic {
    EXACT  = 1'b0,
    APPROX = 1'b1
  } cell_mode_e;

endpackage

// File: rtl/approx_div_row.sv
// One restoring-divider quotient row: D_W subtractor cells in a ripple borrow chain.
module approx_div_row
  import approx_div_pkg::*;
#(
  parameter int D_W = 8
) (
  input  logic [D_W:0]   window,
  input  logic [D_W-1:0] d,
  input  cell_mode_e     mode,
  output logic           qk,
  output logic [D_W-1:0] p_next
);

  logic [D_W-1:0] diff;
  logic           bout;

  // Approximate cells drop the XOR structure: diff saturates toward ones, borrow toward one.
  always_comb begin
    logic b;
    b    = 1'b0;
    diff = '0;
    for (int i = 0; i < D_W; i++) begin
      if (mode == APPROX) begin
        diff[i] = window[i] | d[i] | b;
        b       = window[i] | ~d[i] | b;
      end else begin
        diff[i] = window[i] ^ d[i] ^ b;
        b       = (~window[i] & d[i]) | (~(window[i] ^ d[i]) & b);
      end
    end
    bout = b;
  end

  assign qk     = window[D_W] | ~bout;
  assign p_next = qk ? diff : window[D_W-1:0];

endmodule

// File: rtl/approx_seq_divider.sv
// Iterative restoring divider, one quotient row per clock, with per-request
// choice of approximate cells for the low APPROX_ROWS rows.
//
// state | meaning
// IDLE  | no result held, ready for a request
// BUSY  | computing quotient row k, one row per edge
// DONE  | result held on q/r/dz/ovf until out_ready
module approx_seq_divider
  import approx_div_pkg::*;
#(
  parameter int N_W         = 16,
  parameter int D_W         = 8,
  parameter int APPROX_ROWS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_W-1:0]       n,
  input  logic [D_W-1:0]       d,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_W-D_W-1:0]   q,
  output logic [D_W-1:0]       r,
  output logic                 dz,
  output logic                 ovf
);

  localparam int Q_W = N_W - D_W;
  localparam int K_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  div_state_e     state;
  logic [D_W-1:0] p_reg;
  logic [Q_W-1:0] s_reg;
  logic [K_W-1:0] k_reg;
  logic [D_W-1:0] d_reg;
  logic           approx_reg;

  logic [D_W:0]   window;
  cell_mode_e     row_mode;
  logic           row_qk;
  logic [D_W-1:0] row_p_next;
  logic           accept;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign window   = {p_reg, s_reg[k_reg]};
  assign row_mode = (approx_reg && (int'(k_reg) < APPROX_ROWS)) ? APPROX : EXACT;

  approx_div_row #(
    .D_W (D_W)
  ) u_row (
    .window (window),
    .d      (d_reg),
    .mode   (row_mode),
    .qk     (row_qk),
    .p_next (row_p_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      p_reg      <= '0;
      s_reg      <= '0;
      k_reg      <= '0;
      d_reg      <= '0;
      approx_reg <= 1'b0;
      out_valid  <= 1'b0;
      q          <= '0;
      r          <= '0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
    end else if (accept) begin
      // Accept can happen from IDLE or on the same edge a DONE result is consumed.
      d_reg      <= d;
      approx_reg <= approx_en;
      p_reg      <= n[N_W-1:Q_W];
      s_reg      <= n[Q_W-1:0];
      k_reg      <= K_W'(Q_W - 1);
      if (d == '0) begin
        state     <= DONE;
        out_valid <= 1'b1;
        q         <= '1;
        r         <= n[D_W-1:0];
        dz        <= 1'b1;
        ovf       <= 1'b0;
      end else begin
        state     <= BUSY;
        out_valid <= 1'b0;
        q         <= '0;
        dz        <= 1'b0;
        ovf       <= (n[N_W-1:Q_W] >= d);
      end
    end else begin
      case (state)
        BUSY: begin
          p_reg    <= row_p_next;
          q[k_reg] <= row_qk;
          if (k_reg == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            r         <= row_p_next;
          end else begin
            k_reg <= k_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
